// File: rtl/suma_pkg.sv
// suma_pkg: shared FSM state type and default operand width for the serial adder
package suma_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NBYTES_DEF = 4;
endpackage

// File: rtl/suma_seq_ctrl_if.sv
// suma_seq_ctrl_if: command, operand-stream and sum-stream signals of the serial adder
// slave modport is the adder side, master modport is the requester side.
// ovf exists only when SUMA_SEQ_OVF_EN is defined.
interface suma_seq_ctrl_if;
    logic       start;
    logic       cin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_byte;
    logic       out_last;
    logic       cout;
    logic       done;
    logic       busy;
`ifdef SUMA_SEQ_OVF_EN
    logic       ovf;
`endif
    modport slave (
        input  start, cin, in_valid, a_byte, b_byte, out_ready,
        output in_ready, out_valid, sum_byte, out_last, cout, done, busy
`ifdef SUMA_SEQ_OVF_EN
        , output ovf
`endif
    );
    modport master (
        output start, cin, in_valid, a_byte, b_byte, out_ready,
        input  in_ready, out_valid, sum_byte, out_last, cout, done, busy
`ifdef SUMA_SEQ_OVF_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/suma8_slice.sv
// suma8_slice: combinational 8-bit adder slice
// a, b, ci in; s sum, co carry out; c7 carry into bit 7 (only with SUMA_SEQ_OVF_EN).
module suma8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
`ifdef SUMA_SEQ_OVF_EN
    output logic       c7,
`endif
    output logic [7:0] s,
    output logic       co
);
    logic c7_w;
    assign {c7_w, s[6:0]} = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, ci};
    assign {co, s[7]}     = {1'b0, a[7]} + {1'b0, b[7]} + {1'b0, c7_w};
`ifdef SUMA_SEQ_OVF_EN
    assign c7 = c7_w;
`endif
endmodule

// File: rtl/suma_seq_ctrl.sv
// suma_seq_ctrl: byte-serial NBYTES-wide adder, LSB first, with valid/ready streams
// clk, rst_n (sync active-low); bus (slave): start/cin command, in_valid/in_ready/a_byte/b_byte
// operand stream, out_valid/out_ready/sum_byte/out_last sum stream, cout/done/busy status.
// SUMA_SEQ_OVF_EN adds bus.ovf, the signed overflow of the top byte, valid with done.
module suma_seq_ctrl
    import suma_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    suma_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_t        state, state_nx;
    logic          carry;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    sum_q, s;
    logic          co, out_valid_q, out_last_q, done_q, cout_q;
    logic          in_acc, out_acc, last, fin;
`ifdef SUMA_SEQ_OVF_EN
    logic          c7, ovf_top, ovf_q;
`endif

    assign in_acc  = bus.in_valid && bus.in_ready;
    assign out_acc = out_valid_q && bus.out_ready;
    assign last    = byte_cnt == LAST;
    // last sum byte leaves while in DONE: this is the completion event
    assign fin     = state == DONE && out_acc;

    suma8_slice u_slice (
        .a  (bus.a_byte),
        .b  (bus.b_byte),
        .ci (carry),
`ifdef SUMA_SEQ_OVF_EN
        .c7 (c7),
`endif
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = (in_acc && last) ? DONE : RUN;
            DONE:    state_nx = out_acc ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // an input may be taken only when the output slot is free or draining this cycle
    always_comb begin
        bus.in_ready = rst_n && state == RUN && (!out_valid_q || bus.out_ready);
        bus.busy     = rst_n && state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry       <= 1'b0;
            byte_cnt    <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            cout_q      <= 1'b0;
`ifdef SUMA_SEQ_OVF_EN
            ovf_top     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            done_q <= fin;
            cout_q <= fin && carry;
`ifdef SUMA_SEQ_OVF_EN
            ovf_q  <= fin && ovf_top;
`endif
            if (state == IDLE && bus.start) begin
                carry    <= bus.cin;
                byte_cnt <= '0;
            end
            if (in_acc) begin
                sum_q       <= s;
                carry       <= co;
                out_valid_q <= 1'b1;
                out_last_q  <= last;
                byte_cnt    <= last ? byte_cnt : byte_cnt + 1'b1;
`ifdef SUMA_SEQ_OVF_EN
                ovf_top     <= last ? (c7 ^ co) : ovf_top;
`endif
            end else if (out_acc) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum_byte  = sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.cout      = cout_q;
`ifdef SUMA_SEQ_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: doc/suma_seq_ctrl.md
SUMA_SEQ_CTRL -- requirements
Module: suma_seq_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, meaning the number of operand bytes per addition (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: a pulse that begins one multi-byte addition.
REQ-005 SHALL have port cin, input, 1 bit: carry-in, sampled with start.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), a_byte (input, 8) and b_byte (input, 8): the operand byte-pair stream, least significant byte first.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), sum_byte (output, 8) and out_last (output, 1): the sum byte stream.
REQ-008 SHALL have ports cout (output, 1): the final carry, valid while done=1; done (output, 1): a one-cycle completion pulse; and busy (output, 1): high when not IDLE.

Function
REQ-009 SHALL implement the states IDLE, RUN and DONE.
REQ-010 SHALL, in IDLE with start=1, load carry<=cin and byte_cnt<=0, and go to RUN; start SHALL be ignored outside IDLE.
REQ-011 SHALL drive in_ready=1 only in RUN, and only when (!out_valid || out_ready).
REQ-012 SHALL define an input accept as in_valid && in_ready; on accept it SHALL register sum_byte<=a_byte+b_byte+carry[7:0], update carry<=9th bit, set out_valid<=1 and increment byte_cnt.
REQ-013 SHALL present the sum byte exactly 1 cycle after its accept; sustained throughput SHALL be 1 byte/cycle when out_ready=1.
REQ-014 SHALL hold out_valid, sum_byte and out_last stable while out_valid && !out_ready.
REQ-015 SHALL clear out_valid on an output accept (out_valid && out_ready) unless a new input is accepted in the same cycle.
REQ-016 SHALL, on the accept with byte_cnt==NBYTES-1, set out_last<=1 with that byte and go to DONE; byte_cnt SHALL never wrap inside an operation.
REQ-017 SHALL, in DONE, hold in_ready=0; on the output accept of the last byte it SHALL pulse done=1 for 1 cycle, drive cout=carry during that cycle, and return to IDLE.
REQ-018 SHALL hold cout at 0 whenever done=0.
REQ-019 SHALL allow start to be accepted in the cycle immediately after done.

Reset
REQ-020 SHALL, with rst_n=0 at a clock edge, force the state to IDLE and clear carry, byte_cnt, out_valid, out_last, sum_byte, done, cout and ovf to 0 — including mid-operation; partial results are discarded.
REQ-021 SHALL hold in_ready=0 and busy=0 during reset.

Configuration
REQ-022 SHALL use macro SUMA_SEQ_OVF_EN; when defined, it SHALL add output ovf (1 bit), valid with done and 0 otherwise, equal to the signed overflow of the top byte (carry into bit 7 XOR carry out of bit 7).
REQ-023 SHALL, without SUMA_SEQ_OVF_EN, have no ovf port and no related logic; all other behaviour SHALL be identical.

Structure
REQ-024 SHALL place the state enum (IDLE/RUN/DONE) and the NBYTES default constant in shared package suma_pkg.
REQ-025 SHALL instantiate sub-module suma8_slice, a combinational 8-bit adder with inputs a, b and ci and outputs s, co (and c7 for overflow); the controller SHALL own all registers.

Verification (NBYTES=4, bytes listed LSB first)
REQ-026 SHALL cover: 0x000000FF+0x00000001, cin=0 -> sum bytes 00,01,00,00; out_last on the 4th byte; done with cout=0.
REQ-027 SHALL cover: 0xFFFFFFFF+0x00000001 -> 00,00,00,00; cout=1; with SUMA_SEQ_OVF_EN, ovf=0.
REQ-028 SHALL cover: 0x00000000+0x00000000, cin=1 -> 01,00,00,00; cout=0. Also 0x7FFFFFFF+0x00000001 -> ovf=1.
REQ-029 SHALL cover: out_ready held low for 3 cycles after the 2nd byte -> in_ready=0 and sum_byte stable; no byte is lost or duplicated.
REQ-030 SHALL cover: start pulsed during RUN -> ignored; rst_n=0 after the 2nd byte -> all outputs 0 and IDLE next cycle; a new start then gives a correct result.
